sysreg_cmd_bridge: RTL and testbench
====================================

// Module: sysreg_cmd_bridge
// PURPOSE
//  Upstream front-end for the system register file: accepts read/write commands on a
//  valid/ready channel and drives the file's system port (en/we/addr/din, dout in).
//  Returns one response per command on a valid/ready channel.
//  Range-checks addresses; out-of-range commands never touch the file.
// PARAMETERS
//  ENTRIES     12                   number of registers in the downstream file
//  DATA_WIDTH  32                   register/data width
//  ADDR_WIDTH  $clog2(ENTRIES)      register-file address width (derived, localparam)
//  CMD_AW      8                    command address width (>= ADDR_WIDTH)
// PORTS
//  clk              in   1           single clock, rising edge
//  rst_n            in   1           asynchronous active-low reset
//  cmd_valid        in   1           command present
//  cmd_ready        out  1           bridge accepts command this cycle
//  cmd_we           in   1           1=write, 0=read
//  cmd_addr         in   CMD_AW      register index
//  cmd_wdata        in   DATA_WIDTH  write data
//  rsp_valid        out  1           response present
//  rsp_ready        in   1           consumer takes response
//  rsp_rdata        out  DATA_WIDTH  read data (0 for writes/errors)
//  rsp_err          out  1           address out of range (or readback mismatch, see CONFIG)
//  system_reg_en    out  1           register file enable
//  system_reg_we    out  1           register file write enable
//  system_reg_addr  out  ADDR_WIDTH  register file address
//  system_reg_din   out  DATA_WIDTH  register file write data
//  system_reg_dout  in   DATA_WIDTH  register file read data, valid 1 cycle after en&!we
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   system_reg_en/we=0, addr/din=0. Reset mid-transaction drops the command and its response.
//  FSM: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE; one command in flight, no pipelining.
//  IDLE: cmd_ready=1. On cmd_valid: latch we/addr/wdata. If cmd_addr >= ENTRIES -> RESP
//   with err=1, rdata=0, no register-file access. Else -> ISSUE.
//  ISSUE (1 cycle): en=1, we=latched we, addr=latched addr[ADDR_WIDTH-1:0], din=wdata.
//   Write: file updates at end of this cycle -> RESP, err=0, rdata=0.
//   Read -> WAIT.
//  WAIT (1 cycle): en=0; capture system_reg_dout into rsp_rdata -> RESP.
//  RESP: rsp_valid=1, outputs held stable until rsp_ready=1; then -> IDLE.
//   cmd_ready=0 in all states except IDLE.
//  en/we high only in ISSUE (and VERIFY); single-cycle pulses, never held.
//  Latency: read cmd accept -> rsp_valid = 3 cycles; in-range write = 2; error = 1.
//  Throughput: next command accepted earliest the cycle after the response handshake.
//  rsp_ready asserted before rsp_valid has no effect; cmd_* ignored outside IDLE.
//  Boundary: addr=ENTRIES-1 is legal; addr=ENTRIES and all higher values give err.
// CONFIGURATION
//  SYSREG_BRIDGE_WRCHK_EN defined: after each in-range write, ISSUE -> VERIFY (en=1, we=0,
//   same addr) -> WAIT; if captured dout != wdata, rsp_err=1. rsp_rdata returns the
//   readback value. Write latency becomes 4.
//  Undefined: no VERIFY state; writes respond with rdata=0, err=0.
// STRUCTURE
//  Package sysreg_pkg: ENTRIES/DATA_WIDTH defaults, bridge_state_e enum
//   (IDLE, ISSUE, VERIFY, WAIT, RESP), and the sysreg_cmd_t/sysreg_rsp_t structs.
//  Single flat module. No sub-module is natural.
//  Bench instantiates it in front of register_file and observes reg_values.
// TESTING
//  1 write addr=0 data=32'h00000BEE, rsp_ready=1 -> rsp err=0 after 2 cycles; reg[0]=BEE.
//  2 read addr=0 -> rsp_rdata=32'h00000BEE, err=0, rsp_valid 3 cycles after accept.
//  3 write addr=12 data=FFFFFFFF -> err=1 after 1 cycle; system_reg_en never high;
//    all registers unchanged.
//  4 write addr=11 data=FFFFFFFF with rsp_ready=0 for 5 cycles -> rsp held stable and
//    cmd_ready=0 throughout; back-to-back cmd accepted the cycle after the handshake.
//  5 rst_n pulsed low while in WAIT -> all outputs 0 immediately; no rsp_valid after release.
//  6 WRCHK_EN: write addr=3 data=A5A5A5A5 -> rsp_rdata=A5A5A5A5, err=0, latency 4.

Source files
------------

// File: rtl/sysreg_pkg.sv
// ============================================================================
// sysreg_pkg
// Shared parameters, FSM state type and command/response records for the
// system register file command bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sysreg_pkg;

  localparam int SYSREG_ENTRIES    = 12;
  localparam int SYSREG_DATA_WIDTH = 32;
  localparam int SYSREG_CMD_AW     = 8;
  localparam int SYSREG_ADDR_WIDTH = $clog2(SYSREG_ENTRIES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    VERIFY = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } bridge_state_e;

  // Command as held by the bridge after the range check has passed.
  typedef struct packed {
    logic                         we;
    logic [SYSREG_ADDR_WIDTH-1:0] addr;
    logic [SYSREG_DATA_WIDTH-1:0] wdata;
  } sysreg_cmd_t;

  typedef struct packed {
    logic [SYSREG_DATA_WIDTH-1:0] rdata;
    logic                         err;
  } sysreg_rsp_t;

endpackage

`default_nettype wire

// File: rtl/sysreg_cmd_bridge.sv
// ============================================================================
// sysreg_cmd_bridge
// Valid/ready command front-end for the system register file; one command in
// flight, range-checked addresses. SYSREG_BRIDGE_WRCHK_EN adds write readback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysreg_cmd_bridge
  import sysreg_pkg::*;
#(
  parameter int ENTRIES    = SYSREG_ENTRIES,
  parameter int DATA_WIDTH = SYSREG_DATA_WIDTH,
  parameter int CMD_AW     = SYSREG_CMD_AW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [CMD_AW-1:0]             cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          system_reg_en,
  output logic                          system_reg_we,
  output logic [$clog2(ENTRIES)-1:0]    system_reg_addr,
  output logic [DATA_WIDTH-1:0]         system_reg_din,
  input  logic [DATA_WIDTH-1:0]         system_reg_dout
);

  localparam int                ADDR_WIDTH = $clog2(ENTRIES);
  localparam logic [CMD_AW-1:0] C_ENTRIES  = CMD_AW'(ENTRIES);

  bridge_state_e state_q, state_d;
  sysreg_cmd_t   cmd_q, cmd_d;
  sysreg_rsp_t   rsp_q, rsp_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          addr_oor;

  assign addr_oor = (cmd_addr >= C_ENTRIES);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.we    = cmd_we;
          cmd_d.addr  = cmd_addr[ADDR_WIDTH-1:0];
          cmd_d.wdata = cmd_wdata;
          rsp_d.rdata = '0;
          rsp_d.err   = addr_oor;
          state_d     = addr_oor ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.we) begin
`ifdef SYSREG_BRIDGE_WRCHK_EN
          state_d = VERIFY;
`else
          state_d = RESP;
`endif
        end else begin
          state_d = WAIT;
        end
      end
      VERIFY: state_d = WAIT;
      WAIT: begin
        rsp_d.rdata = system_reg_dout;
`ifdef SYSREG_BRIDGE_WRCHK_EN
        rsp_d.err   = cmd_q.we && (system_reg_dout != cmd_q.wdata);
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so that cmd_ready reads 0 while reset is asserted.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_rdata       = rsp_q.rdata;
  assign rsp_err         = rsp_q.err;
  assign system_reg_en   = (state_q == ISSUE) || (state_q == VERIFY);
  assign system_reg_we   = (state_q == ISSUE) && cmd_q.we;
  assign system_reg_addr = cmd_q.addr;
  assign system_reg_din  = cmd_q.wdata;

endmodule

`default_nettype wire

// File: tb/tb_sysreg_cmd_bridge.sv
// ============================================================================
// tb_sysreg_cmd_bridge
// Bridge in front of a behavioural register file, random commands against an
// array reference model. Honours SYSREG_BRIDGE_WRCHK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sysreg_cmd_bridge;

  localparam int N   = 12;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int RAW = $clog2(N);
`ifdef SYSREG_BRIDGE_WRCHK_EN
  localparam bit WRCHK = 1'b1;
`else
  localparam bit WRCHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_we = 1'b0;
  logic [AW-1:0]  cmd_addr = '0;
  logic [DW-1:0]  cmd_wdata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic           system_reg_en;
  logic           system_reg_we;
  logic [RAW-1:0] system_reg_addr;
  logic [DW-1:0]  system_reg_din;
  logic [DW-1:0]  system_reg_dout;

  always #5 clk = ~clk;

  sysreg_cmd_bridge dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_we          (cmd_we),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .system_reg_en   (system_reg_en),
    .system_reg_we   (system_reg_we),
    .system_reg_addr (system_reg_addr),
    .system_reg_din  (system_reg_din),
    .system_reg_dout (system_reg_dout)
  );

  // Behavioural register file: synchronous write, registered read.
  logic          rf_clear = 1'b1;
  logic [DW-1:0] rf [N];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < N; i++) rf[i] <= '0;
      system_reg_dout <= '0;
    end else if (system_reg_en) begin
      if (system_reg_we) begin
        if (int'(system_reg_addr) < N) rf[system_reg_addr] <= system_reg_din;
      end else begin
        system_reg_dout <= (int'(system_reg_addr) < N) ? rf[system_reg_addr] : 32'hDEAD_DEAD;
      end
    end
  end

  int en_cycles = 0;
  always @(negedge clk) if (system_reg_en) en_cycles++;

  logic [DW-1:0] model [N];
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randomize_busy_inputs();
    cmd_valid = 1'($urandom);
    cmd_we    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    rsp_ready = 1'($urandom);
  endtask

  task automatic do_cmd(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int hold);
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_lat, exp_en, lat, n, en0;
    exp_err   = (int'(addr) >= N);
    exp_rdata = '0;
    if (!exp_err && !we) exp_rdata = model[addr];
    if (!exp_err && we && WRCHK) exp_rdata = wdata;
    exp_lat   = exp_err ? 1 : (we ? (WRCHK ? 4 : 2) : 3);
    exp_en    = exp_err ? 0 : ((we && WRCHK) ? 2 : 1);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'($urandom);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    en0 = en_cycles;
    @(negedge clk);
    lat = 1;
    randomize_busy_inputs();
    while (!rsp_valid && lat < 10) begin
      check_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      lat++;
      randomize_busy_inputs();
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    if (!rsp_valid) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      check_eq("hold_err", 64'(rsp_err), 64'(exp_err));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      randomize_busy_inputs();
      rsp_ready = 1'b0;
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check_eq("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("en_cycles", 64'(en_cycles - en0), 64'(exp_en));

    if (!exp_err && we) model[addr] = wdata;
    if (exp_err) begin
      for (int i = 0; i < N; i++) check_eq("rf_untouched", 64'(rf[i]), 64'(model[i]));
    end else begin
      check_eq("rf_value", 64'(rf[addr]), 64'(model[addr]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check_eq({tag, "_en"}, 64'(system_reg_en), 64'd0);
    check_eq({tag, "_we"}, 64'(system_reg_we), 64'd0);
    check_eq({tag, "_addr"}, 64'(system_reg_addr), 64'd0);
    check_eq({tag, "_din"}, 64'(system_reg_din), 64'd0);
  endtask

  initial begin
    int r;
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rf_clear = 1'b0;
    rst_n    = 1'b1;

    do_cmd(1'b1, 8'd0,  32'h0000_0BEE, 0);
    do_cmd(1'b0, 8'd0,  32'h0,         0);
    do_cmd(1'b1, 8'd12, 32'hFFFF_FFFF, 0);
    do_cmd(1'b1, 8'd11, 32'hFFFF_FFFF, 5);
    do_cmd(1'b0, 8'd11, 32'h0,         0);
    do_cmd(1'b1, 8'd3,  32'hA5A5_A5A5, 0);
    do_cmd(1'b0, 8'd3,  32'h0,         2);
    do_cmd(1'b0, 8'd255, 32'h0,        1);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 7));
      if (r < 6)       a = AW'($urandom_range(0, 15));
      else if (r == 6) a = ($urandom % 2) ? 8'd11 : 8'd12;
      else             a = AW'($urandom);
      do_cmd(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while the read is in its WAIT cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'd5; rsp_ready = 1'b0;
    r = 0;
    while (!cmd_ready && r < 20) begin
      @(negedge clk);
      r++;
    end
    check_eq("rst_test_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    rsp_ready = 1'b0;
    do_cmd(1'b0, 8'd5, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
